// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i pipeline control blocks: forwarding-mux select
// encoding, hazard controller state encoding and the hard-wired zero register.
package rv32i_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_LU_STALL = 2'b01,
        HZ_MEM_WAIT = 2'b10
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Forwarding comparator for one decode source operand. Picks the youngest
// in-flight producer of the register: EX beats WB. A load in EX cannot be
// forwarded (its data does not exist yet), and x0 is never forwarded.
module fwd_match
    import rv32i_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       use_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_we_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_we_i,
    output fwd_sel_e   fwd_sel_o
);

    logic live;
    logic ex_hit;
    logic wb_hit;

    assign live   = use_i && (rs_i != REG_ZERO);
    assign ex_hit = live && ex_we_i && !ex_is_load_i && (rs_i == ex_rd_i);
    assign wb_hit = live && wb_we_i && (rs_i == wb_rd_i);

    // Priority select: EX result is newer than WB result
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (ex_hit) begin
            fwd_sel_o = FWD_EX;
        end else if (wb_hit) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the rv32i core. Drives operand forwarding
// selects, sequences load-use stalls, data-memory wait stalls with a timeout,
// and taken-branch flushes for the IF/ID/EX stages. Keeps a saturating count
// of front-end stall cycles.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             br_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic [1:0]       fwd_sel_rs1,
    output logic [1:0]       fwd_sel_rs2,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    import rv32i_pkg::*;

    localparam int              WC_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT);

    hz_state_e        state_q,     state_d;
    logic [WC_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic             mem_err_q,   mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_e sel_rs1;
    fwd_sel_e sel_rs2;
    logic     load_use;
    logic     stall;
    logic     bubble;
    logic     flush;

    fwd_match u_fwd_rs1 (
        .rs_i         (dec_rs1),
        .use_i        (dec_use_rs1),
        .ex_rd_i      (ex_rd),
        .ex_we_i      (ex_we),
        .ex_is_load_i (ex_is_load),
        .wb_rd_i      (wb_rd),
        .wb_we_i      (wb_we),
        .fwd_sel_o    (sel_rs1)
    );

    fwd_match u_fwd_rs2 (
        .rs_i         (dec_rs2),
        .use_i        (dec_use_rs2),
        .ex_rd_i      (ex_rd),
        .ex_we_i      (ex_we),
        .ex_is_load_i (ex_is_load),
        .wb_rd_i      (wb_rd),
        .wb_we_i      (wb_we),
        .fwd_sel_o    (sel_rs2)
    );

    // A load in EX whose destination is read by the decode instruction
    assign load_use = ex_is_load && ex_we && (ex_rd != REG_ZERO) &&
                      ((dec_use_rs1 && (dec_rs1 == ex_rd)) ||
                       (dec_use_rs2 && (dec_rs2 == ex_rd)));

    // Next-state and stall/flush decode; priority is mem wait > branch > load-use
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = 1'b0;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        case (state_q)
            HZ_MEM_WAIT: begin
                // Exec is frozen here, so a branch indication is stale and ignored
                if (dmem_ready) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else begin
                    stall = 1'b1;
                    if ((wait_cnt_q + WAIT_ONE) == WAIT_LAST) begin
                        // Give up on the access and report it
                        mem_err_d  = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = HZ_RUN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end
            end
            default: begin
                // RUN and the single LU_STALL cycle apply the same rules
                state_d = HZ_RUN;
                if (dmem_req && !dmem_ready) begin
                    stall      = 1'b1;
                    wait_cnt_d = WAIT_ONE;
                    state_d    = HZ_MEM_WAIT;
                end else if (br_taken) begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                end else if (load_use) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = HZ_LU_STALL;
                end
            end
        endcase
    end

    // Saturating count of cycles in which the front end is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter, error pulse and perf counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational controls are forced quiet while reset is held
    assign stall_if    = stall  && !rst;
    assign stall_id    = stall  && !rst;
    assign bubble_ex   = bubble && !rst;
    assign flush_id    = flush  && !rst;
    assign fwd_sel_rs1 = rst ? 2'b00 : sel_rs1;
    assign fwd_sel_rs2 = rst ? 2'b00 : sel_rs2;
    assign mem_err     = mem_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// compared each cycle against a cycle-level behavioural model of the rules.
module tb_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    dec_rs1, dec_rs2, ex_rd, wb_rd;
    logic          dec_use_rs1, dec_use_rs2, ex_we, ex_is_load, wb_we;
    logic          dmem_req, dmem_ready, br_taken;
    logic          stall_if, stall_id, bubble_ex, flush_id, mem_err;
    logic [1:0]    fwd_sel_rs1, fwd_sel_rs2;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: mode 0 = running, 1 = load-use hold, 2 = waiting on dmem
    int m_mode = 0;
    int m_wait = 0;
    int m_cnt  = 0;
    bit m_err  = 1'b0;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_fwd(input logic use_, input logic [4:0] rs);
        if (!use_ || rs == 5'd0) return 2'b00;
        if (ex_we && !ex_is_load && rs == ex_rd) return 2'b01;
        if (wb_we && rs == wb_rd) return 2'b10;
        return 2'b00;
    endfunction

    // Expected {stall_if, stall_id, bubble_ex, flush_id, fwd1, fwd2, mem_err}
    function automatic logic [8:0] model_out();
        logic s, b, f, lu;
        s = 1'b0; b = 1'b0; f = 1'b0;
        if (rst) return {8'b0, m_err};
        lu = ex_is_load && ex_we && ex_rd != 5'd0 &&
             ((dec_use_rs1 && dec_rs1 == ex_rd) || (dec_use_rs2 && dec_rs2 == ex_rd));
        if (m_mode == 2) begin
            s = !dmem_ready;
        end else if (dmem_req && !dmem_ready) begin
            s = 1'b1;
        end else if (br_taken) begin
            b = 1'b1; f = 1'b1;
        end else if (lu) begin
            s = 1'b1; b = 1'b1;
        end
        return {s, s, b, f, m_fwd(dec_use_rs1, dec_rs1), m_fwd(dec_use_rs2, dec_rs2), m_err};
    endfunction

    function automatic logic [8:0] dut_out();
        return {stall_if, stall_id, bubble_ex, flush_id, fwd_sel_rs1, fwd_sel_rs2, mem_err};
    endfunction

    function automatic void model_step();
        logic [8:0] e;
        e = model_out();
        if (rst) begin
            m_mode = 0; m_wait = 0; m_cnt = 0; m_err = 1'b0;
            return;
        end
        if (e[8] && m_cnt < CNT_MAX) m_cnt++;
        m_err = 1'b0;
        if (m_mode == 2) begin
            if (dmem_ready) begin
                m_mode = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1'b1; m_wait = 0; m_mode = 0;
                end
            end
        end else if (e[8] && dmem_req && !dmem_ready) begin
            m_mode = 2; m_wait = 1;
        end else if (e[8]) begin
            m_mode = 1;
        end else begin
            m_mode = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_we = 1'b0; ex_is_load = 1'b0;
        wb_rd = 5'd0; wb_we = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        dec_rs1 = 5'd5; dec_use_rs1 = 1'b1; ex_rd = 5'd5; ex_we = 1'b1;
        dmem_req = 1'b1; br_taken = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if (dut_out() !== 9'b0) $display("FAIL reset_outputs got=%b want=%b", dut_out(), 9'b0);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
        else n_pass++;
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_forwarding();
        // EX hit on rs1, x0 on rs2 never forwarded
        idle_inputs();
        ex_rd = 5'd5; ex_we = 1'b1; dec_rs1 = 5'd5; dec_use_rs1 = 1'b1;
        dec_rs2 = 5'd0; dec_use_rs2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2, stall_if} !== 5'b01_00_0)
            $display("FAIL fwd_ex_rs1 got=%b want=%b", {fwd_sel_rs1, fwd_sel_rs2, stall_if}, 5'b01000);
        else n_pass++;
        tick();
        ex_rd = 5'd0; dec_rs1 = 5'd0;
        @(negedge clk);
        n_checks++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== 4'b0000)
            $display("FAIL fwd_x0 got=%b want=0000", {fwd_sel_rs1, fwd_sel_rs2});
        else n_pass++;
        tick();
        // EX beats WB, then WB once EX stops writing
        ex_rd = 5'd7; wb_rd = 5'd7; ex_we = 1'b1; wb_we = 1'b1;
        dec_rs2 = 5'd7; dec_use_rs2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fwd_sel_rs2 !== 2'b01) $display("FAIL fwd_ex_prio got=%b want=01", fwd_sel_rs2);
        else n_pass++;
        tick();
        ex_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fwd_sel_rs2 !== 2'b10) $display("FAIL fwd_wb got=%b want=10", fwd_sel_rs2);
        else n_pass++;
        tick();
        dec_use_rs2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut_out() !== model_out()) $display("FAIL fwd_unused got=%b want=%b", dut_out(), model_out());
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        int c0;
        idle_inputs();
        c0 = m_cnt;
        ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd3; dec_rs1 = 5'd3; dec_use_rs1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b1110)
            $display("FAIL lu_cycle0 got=%b want=1110", {stall_if, stall_id, bubble_ex, flush_id});
        else n_pass++;
        tick();
        // Bubble now in EX, load has moved to WB
        ex_is_load = 1'b0; ex_we = 1'b0; ex_rd = 5'd0; wb_rd = 5'd3; wb_we = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fwd_sel_rs1, stall_if, bubble_ex} !== 4'b10_0_0)
            $display("FAIL lu_cycle1 got=%b want=1000", {fwd_sel_rs1, stall_if, bubble_ex});
        else n_pass++;
        n_checks++;
        if (int'(stall_cnt) !== c0 + 1) $display("FAIL lu_stall_cnt got=%0d want=%0d", stall_cnt, c0 + 1);
        else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_mem_wait();
        int c0;
        idle_inputs();
        c0 = m_cnt;
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            @(negedge clk);
            n_checks++;
            if (stall_if !== (i != 3)) $display("FAIL memwait_c%0d got=%b want=%b", i, stall_if, i != 3);
            else n_pass++;
            tick();
        end
        dmem_req = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (int'(stall_cnt) !== c0 + 3 || stall_if !== 1'b0)
            $display("FAIL memwait_cnt got=%0d/%b want=%0d/0", stall_cnt, stall_if, c0 + 3);
        else n_pass++;
        tick();
        // Zero-wait access never stalls
        dmem_req = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall_if !== 1'b0) $display("FAIL zero_wait got=%b want=0", stall_if);
        else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        idle_inputs();
        dmem_req = 1'b1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            n_checks++;
            if ({stall_if, mem_err} !== 2'b10) $display("FAIL timeout_wait%0d got=%b want=10", i, {stall_if, mem_err});
            else n_pass++;
            tick();
        end
        dmem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_err === 1'b1) pulses++;
            n_checks++;
            if (mem_err !== (i == 0) || stall_if !== 1'b0)
                $display("FAIL timeout_err%0d got=%b/%b want=%b/0", i, mem_err, stall_if, i == 0);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (pulses != 1) $display("FAIL timeout_pulses got=%0d want=1", pulses);
        else n_pass++;
    endtask

    task automatic test_branch_and_reset();
        idle_inputs();
        br_taken = 1'b1;
        ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd9; dec_rs2 = 5'd9; dec_use_rs2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b0011)
            $display("FAIL br_over_lu got=%b want=0011", {stall_if, stall_id, bubble_ex, flush_id});
        else n_pass++;
        tick();
        idle_inputs();
        dmem_req = 1'b1;
        tick();
        br_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall_if, bubble_ex, flush_id} !== 3'b100)
            $display("FAIL br_in_memwait got=%b want=100", {stall_if, bubble_ex, flush_id});
        else n_pass++;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b0000)
            $display("FAIL rst_in_memwait got=%b want=0000", {stall_if, stall_id, bubble_ex, flush_id});
        else n_pass++;
        tick();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({stall_if, mem_err, stall_cnt} !== {2'b00, {CW{1'b0}}})
            $display("FAIL after_rst got=%b/%b/%0d want=0/0/0", stall_if, mem_err, stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            dec_rs1     = 5'($urandom_range(0, 3));
            dec_rs2     = 5'($urandom_range(0, 3));
            dec_use_rs1 = 1'($urandom);
            dec_use_rs2 = 1'($urandom);
            ex_rd       = 5'($urandom_range(0, 3));
            ex_we       = 1'($urandom);
            ex_is_load  = ($urandom_range(0, 2) == 0);
            wb_rd       = 5'($urandom_range(0, 3));
            wb_we       = 1'($urandom);
            dmem_req    = ($urandom_range(0, 3) == 0) || (m_mode == 2);
            dmem_ready  = ($urandom_range(0, 2) == 0);
            br_taken    = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n_checks++;
            if (dut_out() !== model_out())
                $display("FAIL rand_outs cyc=%0d got=%b want=%b", i, dut_out(), model_out());
            else n_pass++;
            n_checks++;
            if (int'(stall_cnt) !== m_cnt)
                $display("FAIL rand_stall_cnt cyc=%0d got=%0d want=%0d", i, stall_cnt, m_cnt);
            else n_pass++;
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_saturation();
        idle_inputs();
        dmem_req = 1'b1;
        // Repeated timeouts keep stall_if high well beyond the counter range
        for (int i = 0; i < CNT_MAX + 20; i++) tick();
        idle_inputs();
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if (int'(stall_cnt) !== CNT_MAX) $display("FAIL saturate got=%0d want=%0d", stall_cnt, CNT_MAX);
        else n_pass++;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_and_reset();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
